// File: rtl/vpe_pkg.sv
// rtl/vpe_pkg.sv - shared VPE writeback geometry and destination mux encodings
package vpe_pkg;
  localparam int VPE_LANES       = 8;
  localparam int VPE_DW          = VPE_LANES * 8;
  localparam int VPE_RF_DEPTH    = 32;
  localparam int VPE_AW          = $clog2(VPE_RF_DEPTH);
  localparam int VPE_OFIFO_DEPTH = 4;

  localparam logic [1:0] VPE_MUX_BANK_A = 2'd0;
  localparam logic [1:0] VPE_MUX_BANK_B = 2'd1;
  localparam logic [1:0] VPE_MUX_STREAM = 2'd2;
  localparam logic [1:0] VPE_MUX_DROP   = 2'd3;
endpackage

// File: rtl/vpe_wb_ofifo.sv
// rtl/vpe_wb_ofifo.sv - sync output stream FIFO, no fall-through, sticky overflow flag
module vpe_wb_ofifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic [DW-1:0] out_data,
  output logic          out_v,
  input  logic          out_rdy,
  output logic          ovf_err,
  input  logic          clr_err
);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, pop, accept;

  assign full     = (count == (PW+1)'(DEPTH));
  assign out_v    = (count != '0);
  assign out_data = mem[rd_ptr];
  assign pop      = out_v & out_rdy;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign accept   = push & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;
      if (push && !accept)     ovf_err <= 1'b1;
      else if (clr_err)        ovf_err <= 1'b0;
    end
  end
endmodule

// File: rtl/vpe_result_writeback.sv
// rtl/vpe_result_writeback.sv - VPE result ReLU + commit to RF banks / stream FIFO
// Build option VPE_WB_RD_BYPASS_EN: write-first read of a same-cycle commit.
module vpe_result_writeback
  import vpe_pkg::*;
#(
  parameter int LANES       = VPE_LANES,
  parameter int DW          = VPE_DW,
  parameter int RF_DEPTH    = VPE_RF_DEPTH,
  parameter int AW          = VPE_AW,
  parameter int OFIFO_DEPTH = VPE_OFIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_data,
  input  logic          i_data_v,
  input  logic          i_en_relu,
  input  logic [AW-1:0] i_rf_idx,
  input  logic [1:0]    i_rf_mux,
  input  logic          i_rd_en,
  input  logic          i_rd_bank,
  input  logic [AW-1:0] i_rd_idx,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_v,
  input  logic [1:0]    i_clr_bank,
  output logic [1:0]    o_bank_full,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_v,
  input  logic          i_out_rdy,
  output logic          o_ovf_err,
  input  logic          i_clr_err
);
  logic [DW-1:0]       relu_data, rd_word;
  logic [DW-1:0]       rf_a [RF_DEPTH];
  logic [DW-1:0]       rf_b [RF_DEPTH];
  logic [RF_DEPTH-1:0] sb_a, sb_b, sb_a_nxt, sb_b_nxt;
  logic                wr_a, wr_b, push;

  for (genvar g = 0; g < LANES; g++) begin : g_relu
    assign relu_data[8*g +: 8] = (i_en_relu && i_data[8*g+7]) ? 8'h00 : i_data[8*g +: 8];
  end

  assign wr_a = i_data_v && (i_rf_mux == VPE_MUX_BANK_A);
  assign wr_b = i_data_v && (i_rf_mux == VPE_MUX_BANK_B);
  assign push = i_data_v && (i_rf_mux == VPE_MUX_STREAM);

  always_ff @(posedge clk) begin
    if (wr_a) rf_a[i_rf_idx] <= relu_data;
    if (wr_b) rf_b[i_rf_idx] <= relu_data;
  end

  always_comb begin
    rd_word = i_rd_bank ? rf_b[i_rd_idx] : rf_a[i_rd_idx];
`ifdef VPE_WB_RD_BYPASS_EN
    if ((i_rd_bank ? wr_b : wr_a) && (i_rf_idx == i_rd_idx)) rd_word = relu_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_v    <= 1'b0;
      o_rd_data <= '0;
    end else begin
      o_rd_v <= i_rd_en;
      if (i_rd_en) o_rd_data <= rd_word;
    end
  end

  // Clear first, then the same-cycle write marks its own entry.
  always_comb begin
    sb_a_nxt = i_clr_bank[0] ? '0 : sb_a;
    sb_b_nxt = i_clr_bank[1] ? '0 : sb_b;
    if (wr_a) sb_a_nxt[i_rf_idx] = 1'b1;
    if (wr_b) sb_b_nxt[i_rf_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_a        <= '0;
      sb_b        <= '0;
      o_bank_full <= 2'b00;
    end else begin
      sb_a        <= sb_a_nxt;
      sb_b        <= sb_b_nxt;
      o_bank_full <= {&sb_b_nxt, &sb_a_nxt};
    end
  end

  vpe_wb_ofifo #(.DW(DW), .DEPTH(OFIFO_DEPTH)) u_ofifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (relu_data),
    .out_data  (o_out_data),
    .out_v     (o_out_v),
    .out_rdy   (i_out_rdy),
    .ovf_err   (o_ovf_err),
    .clr_err   (i_clr_err)
  );
endmodule

// File: tb/tb_vpe_result_writeback.sv
// tb/tb_vpe_result_writeback.sv - directed + random bench with behavioural reference model
module tb_vpe_result_writeback;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] i_data;
  logic        i_data_v, i_en_relu;
  logic [4:0]  i_rf_idx;
  logic [1:0]  i_rf_mux;
  logic        i_rd_en, i_rd_bank;
  logic [4:0]  i_rd_idx;
  logic [63:0] o_rd_data;
  logic        o_rd_v;
  logic [1:0]  i_clr_bank;
  logic [1:0]  o_bank_full;
  logic [63:0] o_out_data;
  logic        o_out_v, i_out_rdy, o_ovf_err, i_clr_err;

  int checks = 0;
  int failures = 0;

  logic [63:0] m_rf [2][32];
  bit          m_known [2][32];
  bit   [31:0] m_sb [2];
  logic [63:0] m_q [$];
  bit          m_ovf, m_rd_v, m_rd_known;
  logic [63:0] m_rd_data;

  always #5 clk = ~clk;

  vpe_result_writeback dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_data_v(i_data_v), .i_en_relu(i_en_relu),
    .i_rf_idx(i_rf_idx), .i_rf_mux(i_rf_mux), .i_rd_en(i_rd_en), .i_rd_bank(i_rd_bank),
    .i_rd_idx(i_rd_idx), .o_rd_data(o_rd_data), .o_rd_v(o_rd_v), .i_clr_bank(i_clr_bank),
    .o_bank_full(o_bank_full), .o_out_data(o_out_data), .o_out_v(o_out_v),
    .i_out_rdy(i_out_rdy), .o_ovf_err(o_ovf_err), .i_clr_err(i_clr_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] relu_ref(input logic [63:0] d, input logic en);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      byte b;
      b = d[8*i +: 8];
      r[8*i +: 8] = (en && b < 0) ? 8'h00 : d[8*i +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_sb[0] = '0; m_sb[1] = '0;
    m_ovf = 0; m_rd_v = 0; m_rd_data = '0; m_rd_known = 1;
  endtask

  task automatic idle();
    i_data = '0; i_data_v = 0; i_en_relu = 0; i_rf_idx = '0; i_rf_mux = 2'd3;
    i_rd_en = 0; i_rd_bank = 0; i_rd_idx = '0; i_clr_bank = 2'b00;
    i_out_rdy = 0; i_clr_err = 0;
  endtask

  task automatic wr(input logic [63:0] d, input logic relu, input logic [1:0] mux, input int idx);
    i_data = d; i_en_relu = relu; i_rf_mux = mux; i_rf_idx = 5'(idx); i_data_v = 1;
  endtask

  task automatic rd(input logic bank, input int idx);
    i_rd_en = 1; i_rd_bank = bank; i_rd_idx = 5'(idx);
  endtask

  task automatic compare();
    check("rd_v", o_rd_v, m_rd_v);
    if (m_rd_known) check("rd_data", o_rd_data, m_rd_data);
    check("bank_full", o_bank_full, {&m_sb[1], &m_sb[0]});
    check("out_v", o_out_v, m_q.size() != 0);
    if (m_q.size() != 0) check("out_data", o_out_data, m_q[0]);
    check("ovf_err", o_ovf_err, m_ovf);
  endtask

  task automatic cycle();
    logic [63:0] w;
    bit pop, hit, new_ovf;
    int b;
    @(posedge clk);
    w = relu_ref(i_data, i_en_relu);
    m_rd_v = i_rd_en;
    if (i_rd_en) begin
      hit = i_data_v && i_rf_mux == {1'b0, i_rd_bank} && i_rf_idx == i_rd_idx;
`ifndef VPE_WB_RD_BYPASS_EN
      hit = 0;
`endif
      if (hit) begin
        m_rd_data = w; m_rd_known = 1;
      end else begin
        m_rd_data = m_rf[i_rd_bank][i_rd_idx]; m_rd_known = m_known[i_rd_bank][i_rd_idx];
      end
    end
    for (b = 0; b < 2; b++) begin
      if (i_clr_bank[b]) m_sb[b] = '0;
      if (i_data_v && i_rf_mux == 2'(b)) begin
        m_sb[b][i_rf_idx] = 1'b1;
        m_rf[b][i_rf_idx] = w;
        m_known[b][i_rf_idx] = 1;
      end
    end
    pop = m_q.size() != 0 && i_out_rdy;
    new_ovf = 0;
    if (i_data_v && i_rf_mux == 2'd2 && m_q.size() == 4 && !pop) new_ovf = 1;
    if (pop) void'(m_q.pop_front());
    if (i_data_v && i_rf_mux == 2'd2 && !new_ovf) m_q.push_back(w);
    if (new_ovf) m_ovf = 1;
    else if (i_clr_err) m_ovf = 0;
    #1;
    compare();
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 32; i++) m_known[b][i] = 0;
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    check("rst_out_data", o_out_data, 64'h0);
    check("rst_rd_data", o_rd_data, 64'h0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // ReLU on bank A, pass-through on bank B
    idle(); wr(64'h807F01FF0010F005, 1, 2'd0, 3); cycle();
    idle(); rd(0, 3); cycle();
    check("relu_a3", o_rd_data, 64'h007F010000100005);
    check("relu_a3_v", o_rd_v, 1'b1);
    idle(); wr(64'h807F01FF0010F005, 0, 2'd1, 3); cycle();
    idle(); rd(1, 3); cycle();
    check("norelu_b3", o_rd_data, 64'h807F01FF0010F005);
    idle(); cycle();

    // Read during write, same entry
    idle(); wr(64'h1111111111111111, 0, 2'd0, 7); cycle();
    idle(); wr(64'h2222222222222222, 0, 2'd0, 7); rd(0, 7); cycle();
`ifdef VPE_WB_RD_BYPASS_EN
    check("rdw_a7", o_rd_data, 64'h2222222222222222);
`else
    check("rdw_a7", o_rd_data, 64'h1111111111111111);
`endif

    // Fill bank B, then clear it while writing B[0]
    for (int i = 0; i < 32; i++) begin
      idle(); wr({$urandom, $urandom}, 0, 2'd1, i); cycle();
    end
    check("b_full", o_bank_full[1], 1'b1);
    idle(); wr(64'h0123456789ABCDEF, 0, 2'd1, 0); i_clr_bank = 2'b10; cycle();
    check("b_clr", o_bank_full[1], 1'b0);
    for (int i = 1; i < 32; i++) begin
      idle(); wr({$urandom, $urandom}, 1, 2'd1, i); cycle();
    end
    check("b_refull", o_bank_full[1], 1'b1);

    // Overflow: five words into a depth-4 FIFO with no ready
    for (int i = 0; i < 5; i++) begin
      idle(); wr(64'hA0 + 64'(i), 0, 2'd2, 0); cycle();
    end
    check("ovf_set", o_ovf_err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", o_out_data, 64'hA0 + 64'(i));
      idle(); i_out_rdy = 1; cycle();
    end
    check("drained", o_out_v, 1'b0);
    idle(); i_clr_err = 1; cycle();
    check("ovf_clr", o_ovf_err, 1'b0);

    // Push into a full FIFO while it pops
    for (int i = 0; i < 4; i++) begin
      idle(); wr(64'hB0 + 64'(i), 0, 2'd2, 0); cycle();
    end
    idle(); wr(64'hB4, 0, 2'd2, 0); i_out_rdy = 1; cycle();
    check("full_pop_no_ovf", o_ovf_err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(); wr({$urandom, $urandom}, $urandom % 2, 2'd3, $urandom % 32); cycle();
    end
    for (int i = 1; i < 5; i++) begin
      check("full_pop_order", o_out_data, 64'hB0 + 64'(i));
      idle(); i_out_rdy = 1; cycle();
    end

    // Reset with two words queued
    idle(); wr(64'hC0, 0, 2'd2, 0); cycle();
    idle(); wr(64'hC1, 0, 2'd2, 0); rd(0, 3); cycle();
    #2 rst_n = 0;
    #1;
    model_reset();
    compare();
    check("rst_mid_out_v", o_out_v, 1'b0);
    @(negedge clk);
    rst_n = 1;
    idle();
    @(posedge clk); #1;
    idle(); wr(64'hFF00FF00FF00FF00, 1, 2'd0, 5); cycle();
    idle(); rd(0, 5); cycle();
    check("post_rst_a5", o_rd_data, 64'h0000000000000000);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      i_data     = {$urandom, $urandom};
      i_data_v   = ($urandom % 4) != 0;
      i_en_relu  = $urandom % 2;
      i_rf_mux   = 2'($urandom);
      i_rf_idx   = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      i_rd_en    = $urandom % 2;
      i_rd_bank  = $urandom % 2;
      i_rd_idx   = ($urandom % 2) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      i_clr_bank = (($urandom % 32) == 0) ? 2'($urandom) : 2'b00;
      i_out_rdy  = $urandom % 2;
      i_clr_err  = ($urandom % 8) == 0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
